// File: rtl/spi_host_tx_arb_if.sv
// rtl/spi_host_tx_arb_if.sv - handshake bundle between TX requesters, arbiter and TX FIFO
interface spi_host_tx_arb_if #(
    parameter int BurstW = 4
);
    logic              req0_valid_i;
    logic [31:0]       req0_data_i;
    logic [3:0]        req0_be_i;
    logic              req0_last_i;
    logic              req0_ready_o;
    logic              req1_valid_i;
    logic [31:0]       req1_data_i;
    logic [3:0]        req1_be_i;
    logic              req1_last_i;
    logic              req1_ready_o;
    logic              fifo_valid_o;
    logic [31:0]       fifo_data_o;
    logic [3:0]        fifo_be_o;
    logic              fifo_ready_i;
    logic [BurstW-1:0] burst_max_i;
    logic [1:0]        grant_o;
    logic              busy_o;
    logic [BurstW-1:0] cnt_o;

    modport slave (
        input  req0_valid_i, req0_data_i, req0_be_i, req0_last_i,
        input  req1_valid_i, req1_data_i, req1_be_i, req1_last_i,
        input  fifo_ready_i, burst_max_i,
        output req0_ready_o, req1_ready_o,
        output fifo_valid_o, fifo_data_o, fifo_be_o,
        output grant_o, busy_o, cnt_o
    );

    modport master (
        output req0_valid_i, req0_data_i, req0_be_i, req0_last_i,
        output req1_valid_i, req1_data_i, req1_be_i, req1_last_i,
        output fifo_ready_i, burst_max_i,
        input  req0_ready_o, req1_ready_o,
        input  fifo_valid_o, fifo_data_o, fifo_be_o,
        input  grant_o, busy_o, cnt_o
    );
endinterface

// File: rtl/spi_host_tx_arb.sv
// rtl/spi_host_tx_arb.sv - round-robin burst-locked arbiter of CPU and DMA words into the SPI TX FIFO
module spi_host_tx_arb #(
    parameter int BurstW = 4
) (
    input logic              clk_i,
    input logic              rst_ni,
    spi_host_tx_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, G0, G1} state_e;

    localparam logic [BurstW-1:0] CntOne = 1;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;
    logic [BurstW-1:0] lim_q, lim_d;
    logic [BurstW-1:0] cnt_q, cnt_d;
    logic [BurstW-1:0] cnt_inc;
    logic              fifo_valid;
    logic [31:0]       fifo_data;
    logic [3:0]        fifo_be;
    logic              ready0;
    logic              ready1;
    logic              owner_last;
    logic              handshake;

    assign cnt_inc = cnt_q + CntOne;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            lim_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lim_d      = lim_q;
        cnt_d      = cnt_q;
        fifo_valid = 1'b0;
        fifo_data  = '0;
        fifo_be    = '0;
        ready0     = 1'b0;
        ready1     = 1'b0;
        owner_last = 1'b0;
        handshake  = 1'b0;

        case (state_q)
            IDLE: begin
                // The word limit is sampled only here so a mid-grant change waits for the next grant.
                lim_d = bus.burst_max_i;
                cnt_d = '0;
                if (bus.req0_valid_i && (!bus.req1_valid_i || !prio_q)) begin
                    state_d = G0;
                end else if (bus.req1_valid_i) begin
                    state_d = G1;
                end
            end
            G0: begin
                fifo_valid = bus.req0_valid_i;
                fifo_data  = bus.req0_data_i;
                fifo_be    = bus.req0_be_i;
                ready0     = bus.fifo_ready_i;
                owner_last = bus.req0_last_i;
            end
            G1: begin
                fifo_valid = bus.req1_valid_i;
                fifo_data  = bus.req1_data_i;
                fifo_be    = bus.req1_be_i;
                ready1     = bus.fifo_ready_i;
                owner_last = bus.req1_last_i;
            end
            default: state_d = IDLE;
        endcase

        handshake = fifo_valid && bus.fifo_ready_i;
        if (handshake) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_inc;
            end
            if (owner_last || (lim_q != '0 && cnt_inc == lim_q)) begin
                state_d = IDLE;
                prio_d  = (state_q == G0);
            end
        end
    end

    assign bus.fifo_valid_o = fifo_valid;
    assign bus.fifo_data_o  = fifo_data;
    assign bus.fifo_be_o    = fifo_be;
    assign bus.req0_ready_o = ready0;
    assign bus.req1_ready_o = ready1;
    assign bus.grant_o      = {state_q == G1, state_q == G0};
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.cnt_o        = cnt_q;

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.grant_o));
    a_ready_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.req0_ready_o && bus.req1_ready_o));
    a_idle_quiet: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == IDLE) |-> !bus.fifo_valid_o);
    // A stalled owner must keep presenting the same word until the FIFO takes it.
    a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.fifo_valid_o && !bus.fifo_ready_i) |=>
            (bus.fifo_valid_o && $stable(bus.fifo_data_o) && $stable(bus.fifo_be_o)));
endmodule

// File: tb/tb_spi_host_tx_arb.sv
// tb/tb_spi_host_tx_arb.sv - directed vector bench for spi_host_tx_arb
module tb_spi_host_tx_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    spi_host_tx_arb_if #(.BurstW(4)) bus ();

    spi_host_tx_arb #(.BurstW(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic [3:0]  b0;
        logic        l0;
        logic        v1;
        logic [31:0] d1;
        logic [3:0]  b1;
        logic        l1;
        logic        fr;
        logic [3:0]  bm;
        logic [1:0]  eg;
        logic [3:0]  ec;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  eb;
        logic        er0;
        logic        er1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int v0, input logic [31:0] d0, input int b0, input int l0,
                                input int v1, input logic [31:0] d1, input int b1, input int l1,
                                input int fr, input int bm, input int eg, input int ec,
                                input int ev, input logic [31:0] ed, input int eb,
                                input int er0, input int er1);
        vec_t v;
        v.v0 = v0[0]; v.d0 = d0; v.b0 = b0[3:0]; v.l0 = l0[0];
        v.v1 = v1[0]; v.d1 = d1; v.b1 = b1[3:0]; v.l1 = l1[0];
        v.fr = fr[0]; v.bm = bm[3:0];
        v.eg = eg[1:0]; v.ec = ec[3:0]; v.ev = ev[0]; v.ed = ed; v.eb = eb[3:0];
        v.er0 = er0[0]; v.er1 = er1[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        bus.req0_valid_i = 1'b0; bus.req0_data_i = '0; bus.req0_be_i = '0; bus.req0_last_i = 1'b0;
        bus.req1_valid_i = 1'b0; bus.req1_data_i = '0; bus.req1_be_i = '0; bus.req1_last_i = 1'b0;
        bus.fifo_ready_i = 1'b1; bus.burst_max_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        zero_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        bus.req0_valid_i = v.v0; bus.req0_data_i = v.d0; bus.req0_be_i = v.b0; bus.req0_last_i = v.l0;
        bus.req1_valid_i = v.v1; bus.req1_data_i = v.d1; bus.req1_be_i = v.b1; bus.req1_last_i = v.l1;
        bus.fifo_ready_i = v.fr; bus.burst_max_i = v.bm;
    endtask

    task automatic run_seg(input string tag, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk($sformatf("%s[%0d].grant", tag, i - lo), 32'(bus.grant_o), 32'(vecs[i].eg));
            chk($sformatf("%s[%0d].busy", tag, i - lo), 32'(bus.busy_o), 32'(vecs[i].eg != 2'b00));
            chk($sformatf("%s[%0d].cnt", tag, i - lo), 32'(bus.cnt_o), 32'(vecs[i].ec));
            chk($sformatf("%s[%0d].fvalid", tag, i - lo), 32'(bus.fifo_valid_o), 32'(vecs[i].ev));
            chk($sformatf("%s[%0d].fdata", tag, i - lo), bus.fifo_data_o, vecs[i].ed);
            chk($sformatf("%s[%0d].fbe", tag, i - lo), 32'(bus.fifo_be_o), 32'(vecs[i].eb));
            chk($sformatf("%s[%0d].rdy0", tag, i - lo), 32'(bus.req0_ready_o), 32'(vecs[i].er0));
            chk($sformatf("%s[%0d].rdy1", tag, i - lo), 32'(bus.req1_ready_o), 32'(vecs[i].er1));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".grant"}, 32'(bus.grant_o), 32'd0);
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, ".cnt"}, 32'(bus.cnt_o), 32'd0);
        chk({tag, ".fvalid"}, 32'(bus.fifo_valid_o), 32'd0);
        chk({tag, ".fdata"}, bus.fifo_data_o, 32'd0);
        chk({tag, ".rdy0"}, 32'(bus.req0_ready_o), 32'd0);
        chk({tag, ".rdy1"}, 32'(bus.req1_ready_o), 32'd0);
    endtask

    initial begin
        int s1, s2, s3, s4;

        // single CPU burst of three words, last word carries be=0
        s1 = vecs.size();
        vecs.push_back(mk(1, 32'hA000_0001, 'hF, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hA000_0001, 'hF, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 32'hA000_0001, 'hF, 1, 0));
        vecs.push_back(mk(1, 32'hA000_0002, 'hF, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 32'hA000_0002, 'hF, 1, 0));
        vecs.push_back(mk(1, 32'hA000_0003, 'h0, 1, 0, 0, 0, 0, 1, 0, 1, 2, 1, 32'hA000_0003, 'h0, 1, 0));
        vecs.push_back(mk(0, 32'hA000_0004, 'hF, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'hA000_0004, 'hF, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // tie after reset: single-word bursts alternate 0,1,0,1
        s2 = vecs.size();
        vecs.push_back(mk(1, 32'hB000_0000, 'h3, 1, 1, 32'hC000_0000, 'hC, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hB000_0001, 'h3, 1, 1, 32'hC000_0001, 'hC, 1, 1, 0, 1, 0, 1, 32'hB000_0001, 'h3, 1, 0));
        vecs.push_back(mk(1, 32'hB000_0002, 'h3, 1, 1, 32'hC000_0002, 'hC, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hB000_0003, 'h3, 1, 1, 32'hC000_0003, 'hC, 1, 1, 0, 2, 0, 1, 32'hC000_0003, 'hC, 0, 1));
        vecs.push_back(mk(1, 32'hB000_0004, 'h3, 1, 1, 32'hC000_0004, 'hC, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hB000_0005, 'h3, 1, 1, 32'hC000_0005, 'hC, 1, 1, 0, 1, 0, 1, 32'hB000_0005, 'h3, 1, 0));
        vecs.push_back(mk(1, 32'hB000_0006, 'h3, 1, 1, 32'hC000_0006, 'hC, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hB000_0007, 'h3, 1, 1, 32'hC000_0007, 'hC, 1, 1, 0, 2, 0, 1, 32'hC000_0007, 'hC, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        // burst limit 4 on a lastless DMA stream, limit input disturbed mid-grant
        s3 = vecs.size();
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hD000_0000, 'hF, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hE000_0000, 'h1, 1, 1, 32'hD000_0000, 'hF, 0, 1, 4, 2, 0, 1, 32'hD000_0000, 'hF, 0, 1));
        vecs.push_back(mk(1, 32'hE000_0000, 'h1, 1, 1, 32'hD000_0001, 'hF, 0, 1, 3, 2, 1, 1, 32'hD000_0001, 'hF, 0, 1));
        vecs.push_back(mk(1, 32'hE000_0000, 'h1, 1, 1, 32'hD000_0002, 'hF, 0, 1, 3, 2, 2, 1, 32'hD000_0002, 'hF, 0, 1));
        vecs.push_back(mk(1, 32'hE000_0000, 'h1, 1, 1, 32'hD000_0003, 'hF, 0, 1, 3, 2, 3, 1, 32'hD000_0003, 'hF, 0, 1));
        vecs.push_back(mk(1, 32'hE000_0000, 'h1, 1, 1, 32'hD000_0004, 'hF, 0, 1, 4, 0, 4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hE000_0000, 'h1, 1, 1, 32'hD000_0004, 'hF, 0, 1, 4, 1, 0, 1, 32'hE000_0000, 'h1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hD000_0004, 'hF, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hD000_0004, 'hF, 0, 1, 4, 2, 0, 1, 32'hD000_0004, 'hF, 0, 1));
        s4 = vecs.size();

        zero_inputs();
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        do_reset();
        run_seg("single", s1, s2);
        do_reset();
        run_seg("tie", s2, s3);
        do_reset();
        run_seg("limit", s3, s4);

        // backpressure: FIFO stalls five cycles on the third word
        do_reset();
        @(negedge clk);
        bus.req0_valid_i = 1'b1; bus.req0_be_i = 4'hF; bus.req0_data_i = 32'h7700_0000;
        @(negedge clk);
        @(negedge clk);
        bus.req0_data_i = 32'h7700_0001;
        @(negedge clk);
        bus.req0_data_i = 32'h7700_0002;
        bus.fifo_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk($sformatf("bp[%0d].rdy0", k), 32'(bus.req0_ready_o), 32'd0);
            chk($sformatf("bp[%0d].cnt", k), 32'(bus.cnt_o), 32'd2);
            chk($sformatf("bp[%0d].fdata", k), bus.fifo_data_o, 32'h7700_0002);
            chk($sformatf("bp[%0d].fvalid", k), 32'(bus.fifo_valid_o), 32'd1);
            chk($sformatf("bp[%0d].grant", k), 32'(bus.grant_o), 32'd1);
        end
        @(negedge clk);
        bus.fifo_ready_i = 1'b1;
        #1;
        chk("bp.resume.rdy0", 32'(bus.req0_ready_o), 32'd1);
        chk("bp.resume.cnt", 32'(bus.cnt_o), 32'd2);
        @(negedge clk);
        bus.req0_data_i = 32'h7700_0003; bus.req0_last_i = 1'b1;
        #1;
        chk("bp.last.cnt", 32'(bus.cnt_o), 32'd3);
        chk("bp.last.fdata", bus.fifo_data_o, 32'h7700_0003);
        @(negedge clk);
        bus.req0_valid_i = 1'b0; bus.req0_last_i = 1'b0;
        #1;
        chk("bp.done.grant", 32'(bus.grant_o), 32'd0);
        chk("bp.done.cnt", 32'(bus.cnt_o), 32'd4);

        // reset during the 2nd word of a G1 burst, with prio pointing at req1 beforehand
        do_reset();
        @(negedge clk);
        bus.req0_valid_i = 1'b1; bus.req0_last_i = 1'b1; bus.req0_data_i = 32'h1111_0000;
        @(negedge clk);
        @(negedge clk);
        bus.req0_valid_i = 1'b0; bus.req0_last_i = 1'b0;
        bus.req1_valid_i = 1'b1; bus.req1_data_i = 32'h2222_0000; bus.req1_be_i = 4'hF;
        @(negedge clk);
        @(negedge clk);
        bus.req1_data_i = 32'h2222_0001;
        #1;
        chk("rst.pre.grant", 32'(bus.grant_o), 32'd2);
        chk("rst.pre.cnt", 32'(bus.cnt_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst.mid");
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_valid_i = 1'b1; bus.req0_last_i = 1'b1; bus.req0_data_i = 32'h1111_0001;
        bus.req1_last_i = 1'b1;
        #1;
        chk("rst.post.idle", 32'(bus.grant_o), 32'd0);
        @(negedge clk);
        #1;
        chk("rst.post.grant", 32'(bus.grant_o), 32'd1);
        chk("rst.post.fdata", bus.fifo_data_o, 32'h1111_0001);

        // counter saturation on a 20-word unlimited burst
        do_reset();
        @(negedge clk);
        bus.req0_valid_i = 1'b1; bus.req0_be_i = 4'hF; bus.req0_data_i = 32'h5A00_0000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.req0_data_i = 32'h5A00_0000 + 32'(k);
            bus.req0_last_i = (k == 19);
            #1;
            chk($sformatf("sat[%0d].cnt", k), 32'(bus.cnt_o), (k > 15) ? 32'd15 : 32'(k));
            chk($sformatf("sat[%0d].grant", k), 32'(bus.grant_o), 32'd1);
        end
        @(negedge clk);
        bus.req0_valid_i = 1'b0; bus.req0_last_i = 1'b0;
        #1;
        chk("sat.done.grant", 32'(bus.grant_o), 32'd0);
        chk("sat.done.cnt", 32'(bus.cnt_o), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
